alu_shift_top: RTL and testbench
================================

Name: alu_shift_top

Overview:
- Registered 5-bit integer ALU with a pre-shifter on operand b and ARM-style NZCV flags.
- Operand b is logically shifted left by 0-3 bits (bshift) before the operation selected by ALUControl.
- Result and flags are registered, with one clock of latency.
- Serves as the datapath-execute leaf in the lab CPU and as a standalone ALU exercise.

Parameters:
- WIDTH, 5, data width of a, b, b_sh and Result. All behaviour below is stated for WIDTH=5.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- a  input  WIDTH  operand A, two's complement or unsigned
- b  input  WIDTH  operand B, before the shift
- bshift  input  2  left-shift amount applied to b, 0..3
- ALUControl  input  3  operation select
- Result  output  WIDTH  registered result
- ALUFlags  output  4  registered flags: [3]=N, [2]=Z, [1]=C, [0]=V

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: on a clk edge with reset=1, Result=0 and ALUFlags=4'b0000. Outputs hold these values for as long as reset stays high; reset dominates any input.
- Shifted operand: b_sh = (b << bshift) truncated to WIDTH. Bits shifted out are discarded and zeros are shifted in. bshift=0 passes b unchanged.
- Operation select (ALUControl):
  - 000 ADD: a + b_sh
  - 001 SUB: a - b_sh, computed as a + ~b_sh + 1
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 NOR
  - 110 SLT: signed a < b_sh gives 1, else 0, zero-extended to WIDTH
  - 111 MOV: Result = b_sh
- Flags:
  - N = Result[WIDTH-1].
  - Z = (Result == 0).
  - C, ADD: carry out of bit WIDTH-1.
  - C, SUB: carry out of a + ~b_sh + 1, so C=1 means no borrow.
  - V, ADD: a and b_sh have equal sign and the result sign differs.
  - V, SUB: a and b_sh have different sign and the result sign differs from a.
  - All other opcodes: C=0 and V=0.
- SLT compare: lt = N_sub XOR V_sub, taken from an internal subtraction. The SLT flags are N and Z of the SLT result; C=V=0.
- Latency: inputs sampled at edge k appear on Result/ALUFlags after edge k. There is no handshake, so a new operation is accepted every cycle.
- Combinational path: the combinational part has no state. No latches; every opcode is fully decoded.
- Arithmetic width: WIDTH+1-bit internal sum; Result is the low WIDTH bits.

Optional Feature:
- Macro: ALU_ROTATE_EN.
- Defined: the pre-shifter rotates b left by bshift instead of shifting. Bits leaving the MSB re-enter at the LSB. Example: b=00101, bshift=3 gives b_sh=01001.
- Undefined: logical shift left with zero fill, as specified above.
- Everything else is identical in both builds.

Decomposition:
- Package alu_pkg:
  - 3-bit opcode localparams: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_MOV.
  - Flag index constants: FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module alu_bshift: combinational pre-shifter, parameterised by WIDTH, that holds the ALU_ROTATE_EN selection.
- Top level: adder/logic mux, flag generation and output registers.

Test Plan:
- Basic ADD: a=3, b=5, bshift=1, op=000 -> one clk later Result=13 (01101), ALUFlags=0000.
- SUB equal: a=5, b=5, bshift=0, op=001 -> Result=0, ALUFlags=0110 (Z=1, C=1).
- ADD signed overflow: a=15, b=1, bshift=0, op=000 -> Result=16 (10000), ALUFlags=1001 (N=1, V=1).
- ADD unsigned wrap: a=31, b=1, op=000 -> Result=0, ALUFlags=0110.
- Shift truncation: b=5, bshift=3, op=111 -> Result=8 (01000), ALUFlags=0000; with ALU_ROTATE_EN -> Result=9.
- SLT: a=31 (-1), b=1, bshift=0, op=110 -> Result=1, ALUFlags=0000.
- Reset mid-stream: after the SLT case, hold reset=1 for 2 edges with inputs unchanged -> Result=0, ALUFlags=0000 throughout. Release reset -> the next edge shows the computed values again.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared constants for the registered shift-ALU (alu_shift_top) and its
// pre-shifter (alu_bshift).
//
// Contents:
//   aluOp_t              3-bit operation select type
//   OP_ADD .. OP_MOV     opcode values driven on ALUControl
//   FLAG_N/Z/C/V         bit positions of the NZCV flags inside ALUFlags
//   ALU_DEFAULT_WIDTH    default datapath width used by the lab CPU
//
// Build option: ALU_ROTATE_EN (see alu_bshift) changes the pre-shifter from
// a zero-fill left shift into a left rotate. Nothing in this package depends
// on it.
// -----------------------------------------------------------------------------
package alu_pkg;

  // Operation select carried on ALUControl.
  typedef logic [2:0] aluOp_t;

  localparam aluOp_t OP_ADD = 3'b000;
  localparam aluOp_t OP_SUB = 3'b001;
  localparam aluOp_t OP_AND = 3'b010;
  localparam aluOp_t OP_OR  = 3'b011;
  localparam aluOp_t OP_XOR = 3'b100;
  localparam aluOp_t OP_NOR = 3'b101;
  localparam aluOp_t OP_SLT = 3'b110;
  localparam aluOp_t OP_MOV = 3'b111;

  // Positions of the ARM-style condition flags inside the 4-bit flag word.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Datapath width used by the lab CPU.
  localparam int ALU_DEFAULT_WIDTH = 5;

endpackage

// File: rtl/alu_bshift.sv
// -----------------------------------------------------------------------------
// alu_bshift
// Purely combinational pre-shifter for ALU operand b.
//
// Ports:
//   b       in  [WIDTH-1:0]  operand before shifting
//   bshift  in  [1:0]        left shift amount, 0..3
//   bSh     out [WIDTH-1:0]  shifted operand
//
// Build option ALU_ROTATE_EN:
//   undefined  logical shift left, zero fill, bits leaving the MSB are lost
//   defined    rotate left, bits leaving the MSB re-enter at the LSB
// -----------------------------------------------------------------------------
module alu_bshift
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       bshift,
  output logic [WIDTH-1:0] bSh
);

`ifdef ALU_ROTATE_EN
  // Rotation is done by shifting two back-to-back copies of b and keeping
  // the upper copy: whatever falls off the top of the upper copy is exactly
  // what the lower copy pushes in at the bottom.
  logic [2*WIDTH-1:0] doubled;

  always_comb begin
    doubled = {b, b} << bshift;
    bSh     = doubled[2*WIDTH-1:WIDTH];
  end
`else
  // Plain logical left shift. Assigning into a WIDTH-bit target discards
  // the bits shifted past the MSB and the shift operator fills with zeros.
  always_comb begin
    bSh = b << bshift;
  end
`endif

endmodule

// File: rtl/alu_shift_top.sv
// -----------------------------------------------------------------------------
// alu_shift_top
// Registered integer ALU with a 0..3 bit pre-shifter on operand b and
// ARM-style NZCV flags. One clock of latency, a new operation every cycle.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high; clears Result and ALUFlags
//   a           in   [WIDTH-1:0]  operand A
//   b           in   [WIDTH-1:0]  operand B, before pre-shift
//   bshift      in   [1:0]        left shift/rotate amount for b
//   ALUControl  in   [2:0]        operation select (see alu_pkg OP_*)
//   Result      out  [WIDTH-1:0]  registered result
//   ALUFlags    out  [3:0]        registered flags {N, Z, C, V}
//
// Build option: ALU_ROTATE_EN turns the pre-shift into a rotate
// (implemented in alu_bshift); everything else is the same in both builds.
// -----------------------------------------------------------------------------
module alu_shift_top
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       bshift,
  input  logic [2:0]       ALUControl,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       ALUFlags
);

  logic [WIDTH-1:0] bSh;
  logic [WIDTH:0]   addSum;
  logic [WIDTH:0]   subSum;
  logic             addOverflow;
  logic             subOverflow;
  logic             subNegative;
  logic             lessThan;
  logic [WIDTH-1:0] resultNext;
  logic             carryNext;
  logic             overflowNext;
  logic [3:0]       flagsNext;

  alu_bshift #(
    .WIDTH (WIDTH)
  ) u_bshift (
    .b      (b),
    .bshift (bshift),
    .bSh    (bSh)
  );

  // Both arithmetic paths are kept one bit wider than the datapath so the
  // top bit is the carry out. Subtraction is a + ~b_sh + 1, which makes the
  // carry mean "no borrow" in the ARM sense.
  assign addSum = {1'b0, a} + {1'b0, bSh};
  assign subSum = {1'b0, a} + {1'b0, ~bSh} + {{WIDTH{1'b0}}, 1'b1};

  // Two's complement overflow: for ADD the operands agree in sign but the
  // sum does not; for SUB the operands differ in sign and the difference
  // has left the sign of a.
  assign addOverflow = (a[WIDTH-1] == bSh[WIDTH-1]) &&
                       (addSum[WIDTH-1] != a[WIDTH-1]);
  assign subOverflow = (a[WIDTH-1] != bSh[WIDTH-1]) &&
                       (subSum[WIDTH-1] != a[WIDTH-1]);

  // Signed less-than reuses the subtractor: the sign of the difference is
  // wrong exactly when it overflowed, so N xor V gives the true ordering.
  assign subNegative = subSum[WIDTH-1];
  assign lessThan    = subNegative ^ subOverflow;

  // Operation mux. C and V default to zero so only the arithmetic opcodes
  // can raise them; every opcode is listed so nothing latches.
  always_comb begin
    resultNext   = '0;
    carryNext    = 1'b0;
    overflowNext = 1'b0;
    case (ALUControl)
      OP_ADD: begin
        resultNext   = addSum[WIDTH-1:0];
        carryNext    = addSum[WIDTH];
        overflowNext = addOverflow;
      end
      OP_SUB: begin
        resultNext   = subSum[WIDTH-1:0];
        carryNext    = subSum[WIDTH];
        overflowNext = subOverflow;
      end
      OP_AND:  resultNext = a & bSh;
      OP_OR:   resultNext = a | bSh;
      OP_XOR:  resultNext = a ^ bSh;
      OP_NOR:  resultNext = ~(a | bSh);
      OP_SLT:  resultNext = {{(WIDTH-1){1'b0}}, lessThan};
      OP_MOV:  resultNext = bSh;
      default: resultNext = '0;
    endcase
  end

  // N and Z always describe the value being registered, including SLT's
  // zero-extended 0/1.
  always_comb begin
    flagsNext         = 4'b0000;
    flagsNext[FLAG_N] = resultNext[WIDTH-1];
    flagsNext[FLAG_Z] = (resultNext == '0);
    flagsNext[FLAG_C] = carryNext;
    flagsNext[FLAG_V] = overflowNext;
  end

  // Output registers. Reset is sampled on the clock edge and overrides any
  // operation presented in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      Result   <= '0;
      ALUFlags <= 4'b0000;
    end else begin
      Result   <= resultNext;
      ALUFlags <= flagsNext;
    end
  end

endmodule

// File: tb/tb_alu_shift_top.sv
// -----------------------------------------------------------------------------
// tb_alu_shift_top
// Self-checking bench for alu_shift_top (WIDTH=5). Stimulus is driven on the
// falling edge and the expected response is queued; a monitor checks the
// registered outputs just after every rising edge. Expected values come
// either from known constants or from an integer-arithmetic reference model.
// Honours ALU_ROTATE_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_alu_shift_top;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] a;
  logic [4:0] b;
  logic [1:0] bshift;
  logic [2:0] ALUControl;
  logic [4:0] Result;
  logic [3:0] ALUFlags;

  typedef struct {
    logic [4:0] res;
    logic [3:0] flags;
    int         id;
  } exp_t;

  exp_t sbQueue[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   issued     = 0;

  alu_shift_top #(
    .WIDTH (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .a          (a),
    .b          (b),
    .bshift     (bshift),
    .ALUControl (ALUControl),
    .Result     (Result),
    .ALUFlags   (ALUFlags)
  );

  // 10 time-unit clock.
  always #5 clk = ~clk;

  // Reference model working on plain integers: values 0..31, signed view
  // -16..15, carry and overflow decided by range checks.
  function automatic exp_t model(input logic rst, input int av, input int bv,
                                 input int sh, input int op);
    exp_t e;
    int bs;
    int sa;
    int sb;
    int full;
    int sres;
    int res;
    int c;
    int v;
    e.id = 0;
    if (rst) begin
      e.res   = 5'd0;
      e.flags = 4'd0;
      return e;
    end
`ifdef ALU_ROTATE_EN
    bs = ((bv * (1 << sh)) + (bv >> (5 - sh))) % 32;
`else
    bs = (bv * (1 << sh)) % 32;
`endif
    sa = (av >= 16) ? av - 32 : av;
    sb = (bs >= 16) ? bs - 32 : bs;
    c = 0;
    v = 0;
    case (op)
      0: begin
        full = av + bs;
        res  = full % 32;
        c    = (full > 31) ? 1 : 0;
        sres = sa + sb;
        v    = (sres > 15 || sres < -16) ? 1 : 0;
      end
      1: begin
        full = av - bs;
        res  = (full + 32) % 32;
        c    = (av >= bs) ? 1 : 0;
        sres = sa - sb;
        v    = (sres > 15 || sres < -16) ? 1 : 0;
      end
      2: res = av & bs;
      3: res = av | bs;
      4: res = av ^ bs;
      5: res = 31 - (av | bs);
      6: res = (sa < sb) ? 1 : 0;
      default: res = bs;
    endcase
    e.res   = 5'(res);
    e.flags = {(res >= 16), (res == 0), (c != 0), (v != 0)};
    return e;
  endfunction

  // Drive one operation on the falling edge and queue what must appear after
  // the next rising edge. useConst selects a hand-derived expectation.
  task automatic applyStimulus(input logic rst, input logic [4:0] aIn,
                               input logic [4:0] bIn, input logic [1:0] shIn,
                               input logic [2:0] opIn, input bit useConst,
                               input logic [4:0] cRes, input logic [3:0] cFlags);
    exp_t e;
    @(negedge clk);
    reset      = rst;
    a          = aIn;
    b          = bIn;
    bshift     = shIn;
    ALUControl = opIn;
    e = model(rst, int'(aIn), int'(bIn), int'(shIn), int'(opIn));
    if (useConst) begin
      e.res   = cRes;
      e.flags = cFlags;
    end
    e.id = issued;
    issued++;
    sbQueue.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    compared++;
    if (Result !== e.res) begin
      mismatched++;
      $display("[TB] FAIL result op#%0d: got %b, expected %b", e.id, Result, e.res);
    end
    compared++;
    if (ALUFlags !== e.flags) begin
      mismatched++;
      $display("[TB] FAIL flags op#%0d: got %b, expected %b", e.id, ALUFlags, e.flags);
    end
  endtask

  // Monitor: the DUT presents a fresh result after every rising edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sbQueue.size() > 0) begin
      e = sbQueue.pop_front();
      checkOutput(e);
    end
  end

  initial begin
    logic [4:0] movExp;
    int         waitCycles;
    logic       rst;
`ifdef ALU_ROTATE_EN
    movExp = 5'd9;
`else
    movExp = 5'd8;
`endif
    reset      = 1'b1;
    a          = '0;
    b          = '0;
    bshift     = '0;
    ALUControl = '0;

    $display("[TB] start");
    applyStimulus(1'b1, 5'd7, 5'd9, 2'd1, 3'b000, 1'b1, 5'd0, 4'b0000);
    applyStimulus(1'b1, 5'd7, 5'd9, 2'd1, 3'b000, 1'b1, 5'd0, 4'b0000);

    // Hand-derived cases.
    applyStimulus(1'b0, 5'd3,  5'd5, 2'd1, 3'b000, 1'b1, 5'd13, 4'b0000);
    applyStimulus(1'b0, 5'd5,  5'd5, 2'd0, 3'b001, 1'b1, 5'd0,  4'b0110);
    applyStimulus(1'b0, 5'd15, 5'd1, 2'd0, 3'b000, 1'b1, 5'd16, 4'b1001);
    applyStimulus(1'b0, 5'd31, 5'd1, 2'd0, 3'b000, 1'b1, 5'd0,  4'b0110);
    applyStimulus(1'b0, 5'd0,  5'd5, 2'd3, 3'b111, 1'b1, movExp, 4'b0000);
    applyStimulus(1'b0, 5'd31, 5'd1, 2'd0, 3'b110, 1'b1, 5'd1,  4'b0000);
    applyStimulus(1'b1, 5'd31, 5'd1, 2'd0, 3'b110, 1'b1, 5'd0,  4'b0000);
    applyStimulus(1'b1, 5'd31, 5'd1, 2'd0, 3'b110, 1'b1, 5'd0,  4'b0000);
    applyStimulus(1'b0, 5'd31, 5'd1, 2'd0, 3'b110, 1'b1, 5'd1,  4'b0000);
    applyStimulus(1'b0, 5'd1,  5'd2, 2'd0, 3'b001, 1'b1, 5'd31, 4'b1000);
    applyStimulus(1'b0, 5'd16, 5'd1, 2'd0, 3'b001, 1'b1, 5'd15, 4'b0011);
    applyStimulus(1'b0, 5'd10, 5'd12, 2'd0, 3'b101, 1'b1, 5'd17, 4'b1000);

    // Every opcode with every shift amount, then random traffic with
    // occasional resets, all against the reference model.
    for (int op = 0; op < 8; op++) begin
      for (int sh = 0; sh < 4; sh++) begin
        applyStimulus(1'b0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                      2'(sh), 3'(op), 1'b0, 5'd0, 4'd0);
      end
    end
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 19) == 0);
      applyStimulus(rst, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                    2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                    1'b0, 5'd0, 4'd0);
    end

    // Let the monitor drain the queue, but never wait forever.
    waitCycles = 0;
    while (sbQueue.size() > 0 && waitCycles < 10) begin
      @(posedge clk);
      waitCycles++;
    end
    #2;
    if (sbQueue.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain: %0d results outstanding, expected 0", sbQueue.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
